uart_tx_parity: RTL and testbench

UART_TX_PARITY -- requirements
Module: uart_tx_parity

---
 rtl/uart_tx_parity.sv | 152 +++++++++++++++
 tb/tb_uart_tx_parity.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_parity.sv
// UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, stop.
// Define UART_TX_PARITY_EN to build the parity stage; without it frames carry no parity bit.
module uart_tx_parity #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  is_even_parity,
    input  logic                  parity_fault_injection,
    output logic                  TXD,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int CW = $clog2(BAUD_DIV);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic   [CW-1:0]       baud_q;
    logic   [BW-1:0]       bit_q;
    logic   [BW-1:0]       bit_nxt;
    logic   [DATA_WIDTH-1:0] data_q;
    logic                  txd_d;
    logic                  baud_last;
    logic                  bit_last;
    logic                  handshake;

`ifdef UART_TX_PARITY_EN
    logic                  even_q;
    logic                  fault_q;
    logic                  parity_bit;

    // Odd parity is the complement of the even parity bit; fault flips it.
    assign parity_bit = (^data_q) ^ ~even_q ^ fault_q;
`else
    logic                  unused_par;

    assign unused_par = is_even_parity ^ parity_fault_injection;
`endif

    assign baud_last = (baud_q == CW'(BAUD_DIV - 1));
    assign bit_last  = (bit_q == BW'(DATA_WIDTH - 1));
    assign bit_nxt   = bit_q + BW'(1);
    assign tx_ready  = (state_q == IDLE);
    assign tx_busy   = (state_q != IDLE);
    assign tx_done   = (state_q == STOP) && baud_last;
    assign handshake = tx_valid && tx_ready;

    // Next state, and the line level for the next cycle so TXD can be registered.
    always_comb begin
        state_d = state_q;
        txd_d   = TXD;
        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (tx_valid) begin
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    txd_d   = data_q[0];
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_last) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = parity_bit;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        txd_d = data_q[bit_nxt];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // State, line, counters and the payload captured at handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            TXD     <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
`ifdef UART_TX_PARITY_EN
            even_q  <= 1'b0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            TXD     <= txd_d;
            if (state_q == IDLE || baud_last) begin
                baud_q <= '0;
            end else begin
                baud_q <= baud_q + CW'(1);
            end
            if (state_q == DATA && baud_last) begin
                bit_q <= bit_last ? '0 : bit_nxt;
            end
            if (handshake) begin
                data_q  <= tx_data;
                bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
                even_q  <= is_even_parity;
                fault_q <= parity_fault_injection;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_parity.sv
// Bench for uart_tx_parity: driver pushes expected frames, line monitor pops and compares.
// Follows UART_TX_PARITY_EN to choose the frame layout.
module tb_uart_tx_parity;

    localparam int BD = 4;
    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          is_even_parity = 1'b1;
    logic          parity_fault_injection = 1'b0;
    logic          TXD;
    logic          tx_busy;
    logic          tx_done;

    int checks = 0;
    int failures = 0;

    logic [15:0] sb[$];

    uart_tx_parity #(.DATA_WIDTH(DW), .BAUD_DIV(BD)) dut (
        .clk(clk),
        .reset(reset),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .is_even_parity(is_even_parity),
        .parity_fault_injection(parity_fault_injection),
        .TXD(TXD),
        .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk_frame(input logic [DW-1:0] d, input logic ev, input logic fl);
        logic [15:0] f;
        int ones;
        f = '0;
        ones = 0;
        for (int i = 0; i < DW; i++) begin
            f[1+i] = d[i];
            ones += int'(d[i]);
        end
`ifdef UART_TX_PARITY_EN
        if (ev) f[DW+1] = ((ones % 2) == 1) ^ fl;
        else    f[DW+1] = ((ones % 2) == 0) ^ fl;
        f[DW+2] = 1'b1;
`else
        f[DW+1] = 1'b1;
        if (ev ^ fl) f[0] = 1'b0;
`endif
        return f;
    endfunction

    // Line monitor: captures each frame mid-bit and scores it against the queue.
    logic [15:0] m_bits;
    logic [15:0] m_exp;
    int          m_done_at;
    int          m_done_n;
    bit          m_abort;
    bit          m_busy_ok;
    bit          m_ready_ok;

    always begin
        @(negedge clk);
        if (!reset && TXD === 1'b0) begin
            m_bits = '0;
            m_done_at = -1;
            m_done_n = 0;
            m_abort = 0;
            m_busy_ok = 1;
            m_ready_ok = 1;
            for (int c = 0; c < NB * BD; c++) begin
                if (c > 0) @(negedge clk);
                if (reset) begin
                    m_abort = 1;
                    break;
                end
                if (c % BD == BD / 2) m_bits[c/BD] = TXD;
                if (tx_done) begin
                    m_done_n++;
                    m_done_at = c;
                end
                if (!tx_busy) m_busy_ok = 0;
                if (tx_ready) m_ready_ok = 0;
            end
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
                m_exp = '1;
            end else begin
                m_exp = sb.pop_front();
            end
            if (m_abort) begin
                check("abort_no_done", 32'(m_done_n), 32'd0);
            end else begin
                check("frame_bits", 32'(m_bits), 32'(m_exp));
                check("done_cycle", 32'(m_done_at), 32'(NB * BD - 1));
                check("done_count", 32'(m_done_n), 32'd1);
                check("busy_frame", 32'(m_busy_ok), 32'd1);
                check("ready_low_frame", 32'(m_ready_ok), 32'd1);
                @(negedge clk);
                check("gap_txd", 32'(TXD), 32'd1);
                check("gap_ready", 32'(tx_ready), 32'd1);
                check("gap_busy", 32'(tx_busy), 32'd0);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!tx_ready) check("ready_timeout", 32'(tx_ready), 32'd1);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic ev, input logic fl, input bit hold);
        wait_ready();
        tx_data = d;
        is_even_parity = ev;
        parity_fault_injection = fl;
        tx_valid = 1'b1;
        sb.push_back(mk_frame(d, ev, fl));
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
        tx_data = ~d;
        is_even_parity = ~ev;
        parity_fault_injection = ~fl;
    endtask

    task automatic settle();
        wait_ready();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_txd", 32'(TXD), 32'd1);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

`ifdef UART_TX_PARITY_EN
        send(8'hA5, 1'b1, 1'b0, 0); settle();
        send(8'hA5, 1'b0, 1'b0, 0); settle();
        send(8'hA5, 1'b1, 1'b1, 0); settle();
        send(8'h00, 1'b0, 1'b0, 0); settle();
        send(8'hFF, 1'b1, 1'b0, 0); settle();
`else
        send(8'h5A, 1'b1, 1'b0, 0); settle();
        send(8'h5A, 1'b0, 1'b1, 0); settle();
        send(8'hA5, 1'b1, 1'b1, 0); settle();
`endif

        send(8'h01, 1'b1, 1'b0, 1);
        send(8'hFF, 1'b1, 1'b0, 0);
        settle();

        // Abort during data bit 3 (cycles 17..20 after the handshake).
        send(8'h3C, 1'b1, 1'b0, 0);
        repeat (16) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_txd", 32'(TXD), 32'd1);
        check("abort_busy", 32'(tx_busy), 32'd0);
        check("abort_ready", 32'(tx_ready), 32'd1);
        repeat (BD * NB) begin
            @(negedge clk);
            if (tx_done) check("abort_late_done", 32'(tx_done), 32'd0);
        end
        @(posedge clk);
        #1;

        // Reset wins over a simultaneous handshake.
        tx_valid = 1'b1;
        tx_data = 8'h55;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tx_valid = 1'b0;
        check("rstprio_busy", 32'(tx_busy), 32'd0);
        check("rstprio_txd", 32'(TXD), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            send(DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            settle();
        end

        begin
            int n = 0;
            while (sb.size() != 0 && n < 400) begin
                @(posedge clk);
                n++;
            end
        end
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
